fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader.sv | 161 ++++++++++++++++
 tb/tb_fifo_reader.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// fifo_reader: pulls a burst of words out of a FIFO with a 1-cycle read
// latency and streams them out over a valid/ready interface through a
// 2-entry in-order skid buffer.
// Optional feature: define FIFO_READER_CHECKSUM_EN to add a per-burst XOR
// checksum output of all words accepted downstream.
//
// state | meaning
// IDLE  | waiting for start; burst_len sampled with start
// READ  | issuing FIFO pops until remaining reaches 0
// DRAIN | all pops issued, waiting for the buffer to empty downstream
// DONE  | one-cycle done pulse, then back to IDLE
module fifo_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
`ifdef FIFO_READER_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksum,
`endif
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic                  busy_q;
    logic                  done_q;

    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;
    logic [1:0]            count_q;

    logic                  accept;
    logic [2:0]            occ_after;

    assign m_valid = (count_q != 2'd0);
    assign m_data  = buf_q[rd_ptr_q];
    assign accept  = m_valid & m_ready;
    assign busy    = busy_q;
    assign done    = done_q;

    // Occupancy the buffer will have after this edge, before any new pop
    // lands. A slot freed by this cycle's accept counts as free, which is
    // what lets the reader sustain one word per cycle with a 2-entry buffer
    // while still guaranteeing returned data always has a slot.
    assign occ_after = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, accept};

    assign fifo_rd_en = (state_q == S_READ) && !fifo_empty &&
                        (remaining_q != '0) && (occ_after < 3'd2);

    // Next-state and remaining-count decode.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        state_d     = S_READ;
                        remaining_d = burst_len;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_READ: begin
                if (fifo_rd_en) begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (accept && (count_q == 2'd1) && !inflight_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state, remaining count and registered busy/done outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            busy_q      <= (state_d == S_READ) || (state_d == S_DRAIN);
            done_q      <= (state_d == S_DONE);
        end
    end

    // Read-return capture into the 2-entry ring; in-flight flag is cleared
    // by reset so data returning from an aborted pop is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            inflight_q <= fifo_rd_en;
            if (inflight_q) begin
                buf_q[wr_ptr_q] <= fifo_rd_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (accept) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= occ_after[1:0];
        end
    end

`ifdef FIFO_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q;

    // XOR of accepted words, restarted whenever a new burst is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_q <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            checksum_q <= '0;
        end else if (accept) begin
            checksum_q <= checksum_q ^ m_data;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed testbench for fifo_reader. A small FIFO model (array + indices)
// returns data one cycle after each sampled pop. Inputs are driven and
// outputs sampled around the falling edge.
module tb_fifo_reader;

    localparam int DW = 8;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] burst_len;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          busy;
    logic          done;
`ifdef FIFO_READER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW-1:0] mem [0:63];
    int            wr_idx = 0;
    int            rd_idx = 0;

    logic [DW-1:0] got [0:15];
    int            n_got, rd_pulses, done_cnt, done_cyc, last_acc;
    int            first_valid, stall_err, empty_rd_err;
    logic          busy_c1;

    fifo_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .burst_len    (burst_len),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .busy         (busy),
`ifdef FIFO_READER_CHECKSUM_EN
        .checksum     (checksum),
`endif
        .done         (done)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_idx == rd_idx);

    // FIFO model: data for a pop sampled at edge E is presented until E+1.
    always @(posedge clk) begin
        if (!rst && fifo_rd_en) begin
            fifo_rd_data <= mem[rd_idx];
            rd_idx       <= rd_idx + 1;
        end
    end

    task automatic push(input logic [DW-1:0] d);
        mem[wr_idx] = d;
        wr_idx = wr_idx + 1;
    endtask

    // Runs one burst, logging what the DUT did. Cycle c=0 is the start cycle.
    // mode 0: m_ready always 1; mode 1: m_ready 1,0,0 repeating.
    task automatic run_burst(input int len, input int mode, input int push_at,
                             input logic [DW-1:0] p0, input logic [DW-1:0] p1);
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        n_got = 0; rd_pulses = 0; done_cnt = 0; done_cyc = -1; last_acc = -1;
        first_valid = -1; stall_err = 0; empty_rd_err = 0; busy_c1 = 1'b0;
        prev_stall = 1'b0; prev_data = '0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (c == push_at) begin
                push(p0);
                push(p1);
            end
            start     = (c == 0);
            burst_len = LW'(len);
            m_ready   = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            #1;
            if (fifo_rd_en === 1'b1) rd_pulses++;
            if (fifo_rd_en === 1'b1 && fifo_empty) empty_rd_err++;
            if (c == 1) busy_c1 = busy;
            if (m_valid === 1'b1 && first_valid < 0) first_valid = c;
            if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data)) stall_err++;
            prev_stall = (m_valid === 1'b1) && !m_ready;
            prev_data  = m_data;
            if (m_valid === 1'b1 && m_ready) begin
                if (n_got < 16) got[n_got] = m_data;
                n_got++;
                last_acc = c;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = c;
            end
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; burst_len = '0; m_ready = 1'b0;
        #1;
        tests_run++;
        if ({fifo_rd_en, m_valid, busy, done, m_data} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got rd_en=%b valid=%b busy=%b done=%b data=%0h, expected all 0",
                     fifo_rd_en, m_valid, busy, done, m_data);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if ({fifo_rd_en, m_valid, busy, done} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got rd_en=%b valid=%b busy=%b done=%b, expected 0000",
                     fifo_rd_en, m_valid, busy, done);
        end
    endtask

    task automatic test_stream();
        push(8'd0); push(8'd10); push(8'd20); push(8'd30); push(8'd40);
        run_burst(5, 0, -1, 8'd0, 8'd0);
        tests_run++;
        if (n_got !== 5) begin
            tests_failed++;
            $display("FAIL stream_count: got %0d words, expected 5", n_got);
        end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (got[i] !== DW'(i * 10)) begin
                tests_failed++;
                $display("FAIL stream_word%0d: got %0d, expected %0d", i, got[i], i * 10);
            end
        end
        tests_run++;
        if (first_valid !== 3) begin
            tests_failed++;
            $display("FAIL stream_latency: first m_valid cycle %0d, expected 3", first_valid);
        end
        tests_run++;
        if (last_acc !== 7) begin
            tests_failed++;
            $display("FAIL stream_throughput: last accept cycle %0d, expected 7", last_acc);
        end
        tests_run++;
        if (rd_pulses !== 5) begin
            tests_failed++;
            $display("FAIL stream_rd_pulses: got %0d, expected 5", rd_pulses);
        end
        tests_run++;
        if (busy_c1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL stream_busy: got %b, expected 1", busy_c1);
        end
        tests_run++;
        if (done_cnt !== 1 || done_cyc !== 8) begin
            tests_failed++;
            $display("FAIL stream_done: got %0d pulses at cycle %0d, expected 1 at 8", done_cnt, done_cyc);
        end
`ifdef FIFO_READER_CHECKSUM_EN
        tests_run++;
        if (checksum !== 8'h28) begin
            tests_failed++;
            $display("FAIL stream_checksum: got %0h, expected 28", checksum);
        end
`endif
    endtask

    task automatic test_backpressure();
        push(8'd0); push(8'd10); push(8'd20); push(8'd30); push(8'd40);
        run_burst(5, 1, -1, 8'd0, 8'd0);
        tests_run++;
        if (n_got !== 5) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d words, expected 5", n_got);
        end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (got[i] !== DW'(i * 10)) begin
                tests_failed++;
                $display("FAIL bp_word%0d: got %0d, expected %0d", i, got[i], i * 10);
            end
        end
        tests_run++;
        if (stall_err !== 0) begin
            tests_failed++;
            $display("FAIL bp_stable: %0d unstable stall cycles, expected 0", stall_err);
        end
        tests_run++;
        if (rd_pulses !== 5) begin
            tests_failed++;
            $display("FAIL bp_rd_pulses: got %0d, expected 5", rd_pulses);
        end
        tests_run++;
        if (last_acc !== 15 || done_cnt !== 1 || done_cyc !== 16) begin
            tests_failed++;
            $display("FAIL bp_done: last accept %0d, done %0d pulses at %0d, expected 15, 1 at 16",
                     last_acc, done_cnt, done_cyc);
        end
    endtask

    task automatic test_empty_stall();
        push(8'd50); push(8'd60);
        run_burst(4, 0, 10, 8'd70, 8'd80);
        tests_run++;
        if (n_got !== 4) begin
            tests_failed++;
            $display("FAIL stall_count: got %0d words, expected 4", n_got);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (got[i] !== DW'(50 + i * 10)) begin
                tests_failed++;
                $display("FAIL stall_word%0d: got %0d, expected %0d", i, got[i], 50 + i * 10);
            end
        end
        tests_run++;
        if (empty_rd_err !== 0 || rd_pulses !== 4) begin
            tests_failed++;
            $display("FAIL stall_rd_en: %0d pops while empty, %0d pops total, expected 0 and 4",
                     empty_rd_err, rd_pulses);
        end
        tests_run++;
        if (last_acc !== 13 || done_cnt !== 1 || done_cyc !== 14) begin
            tests_failed++;
            $display("FAIL stall_done: last accept %0d, done %0d pulses at %0d, expected 13, 1 at 14",
                     last_acc, done_cnt, done_cyc);
        end
    endtask

    task automatic test_zero_len();
        run_burst(0, 0, -1, 8'd0, 8'd0);
        tests_run++;
        if (rd_pulses !== 0 || first_valid !== -1) begin
            tests_failed++;
            $display("FAIL zero_activity: %0d pops, first valid %0d, expected 0 and -1",
                     rd_pulses, first_valid);
        end
        tests_run++;
        if (done_cnt !== 1 || done_cyc !== 1 || busy_c1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_done: %0d pulses at %0d busy=%b, expected 1 at 1 busy=0",
                     done_cnt, done_cyc, busy_c1);
        end
`ifdef FIFO_READER_CHECKSUM_EN
        tests_run++;
        if (checksum !== 8'h00) begin
            tests_failed++;
            $display("FAIL zero_checksum: got %0h, expected 00", checksum);
        end
`endif
    endtask

    task automatic test_reset_mid_burst();
        int   acc;
        logic busy_pre;
        acc = 0;
        push(8'd0); push(8'd10);
        @(negedge clk);
        start = 1'b1; burst_len = LW'(5); m_ready = 1'b1;
        for (int c = 0; c < 20 && acc < 2; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (m_valid === 1'b1) acc++;
        end
        tests_run++;
        if (acc !== 2) begin
            tests_failed++;
            $display("FAIL rst_mid_pre: got %0d words before reset, expected 2", acc);
        end
        @(posedge clk);
        #2;
        busy_pre = busy;
        rst = 1'b1;
        #1;
        tests_run++;
        if (busy_pre !== 1'b1 || {fifo_rd_en, m_valid, busy, done, m_data} !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid_async: busy before=%b, after rd_en=%b valid=%b busy=%b done=%b data=%0h, expected 1 then all 0",
                     busy_pre, fifo_rd_en, m_valid, busy, done, m_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        push(8'd20); push(8'd30); push(8'd40);
        run_burst(3, 0, -1, 8'd0, 8'd0);
        tests_run++;
        if (n_got !== 3 || got[0] !== 8'd20 || got[1] !== 8'd30 || got[2] !== 8'd40) begin
            tests_failed++;
            $display("FAIL rst_mid_resume: got %0d words %0d,%0d,%0d, expected 3 words 20,30,40",
                     n_got, got[0], got[1], got[2]);
        end
        tests_run++;
        if (done_cnt !== 1 || done_cyc !== last_acc + 1) begin
            tests_failed++;
            $display("FAIL rst_mid_done: %0d pulses at %0d, expected 1 at %0d", done_cnt, done_cyc, last_acc + 1);
        end
`ifdef FIFO_READER_CHECKSUM_EN
        tests_run++;
        if (checksum !== 8'h22) begin
            tests_failed++;
            $display("FAIL rst_mid_checksum: got %0h, expected 22", checksum);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_empty_stall();
        test_zero_len();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
